// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input row and packs its
// sampled outputs into the truth-table code, then checks it against a reference.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   code,
  output logic                   match
);

  localparam int W  = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] row_q, row_d;
  logic [N_IN-1:0] din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    code_q, code_d;
  logic [W-1:0]    exp_q, exp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          din_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
          code_d  = '0;
          match_d = 1'b0;
          exp_d   = expected;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Row r lands at bit W-1-r, which is ~r for a power-of-two width
          code_d[~row_q] = dut_out;
          if (row_q != '1) begin
            row_d = row_q + 1'b1;
            din_d = row_q + 1'b1;
            cnt_d = '0;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (code_d == exp_q);
            din_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dut_in = din_q;
    busy   = busy_q;
    done   = done_q;
    code   = code_q;
    match  = match_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: gate models feed two sweeper instances (settle 4 and 1);
// expected codes go through a scoreboard queue and are checked on done.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       sel = 1'b0;
  int         mode = 0;
  int         cyc = 0;
  int         c0 = 0;
  int         ncmp = 0;
  int         nfail = 0;

  logic [2:0] din4, din1;
  logic       dout4, dout1;
  logic       busy4, busy1, done4, done1, match4, match1;
  logic [7:0] code4, code1;

  typedef struct {
    logic [7:0] code;
    logic       m;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) u4 (
    .clk(clk), .reset(reset), .start(start & ~sel),
    .expected(expected), .dut_in(din4), .dut_out(dout4),
    .busy(busy4), .done(done4), .code(code4), .match(match4)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start & sel),
    .expected(expected), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .code(code1), .match(match1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate(int m, logic [2:0] x);
    logic [7:0] r;
    r = 8'h64;
    case (m)
      1:       return 1'b0;
      2:       return ^x;
      default: return r[~x];
    endcase
  endfunction

  // Mode 3 inverts the output except in the last cycle before a sample edge
  always_comb begin
    dout4 = gate(mode, din4);
    if (mode == 3 && ((cyc - c0) % 4) != 3) dout4 = ~dout4;
    dout1 = gate(mode, din1);
  end

  logic       busy_m, done_m, match_m;
  logic [2:0] din_m;
  logic [7:0] code_m;
  assign busy_m  = sel ? busy1  : busy4;
  assign done_m  = sel ? done1  : done4;
  assign match_m = sel ? match1 : match4;
  assign din_m   = sel ? din1   : din4;
  assign code_m  = sel ? code1  : code4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exv);
    ncmp++;
    assert (obs === exv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
    end
  endtask

  task automatic sweep(input int m, input logic [7:0] ex,
                       input logic [7:0] want, input logic wm,
                       input bit inject);
    int s;
    int j;
    exp_t e;
    s = sel ? 1 : 4;
    mode = m;
    expected = ex;
    start = 1'b1;
    step();
    start = 1'b0;
    expected = 8'hAA;
    c0 = cyc;
    sbq.push_back('{code: want, m: wm, lat: 8 * s});
    chk("busy_after_start", 32'(busy_m), 32'd1);
    chk("din_after_start", 32'(din_m), 32'd0);
    chk("done_after_start", 32'(done_m), 32'd0);
    for (j = 1; j <= 200; j++) begin
      step();
      start = 1'b0;
      if (done_m) break;
      if (inject && (j == 3 || j == 10)) begin
        start = 1'b1;
        expected = 8'h00;
      end
      if (j % s == 0 && j < 8 * s)
        chk("din_row", 32'(din_m), 32'(j / s));
    end
    start = 1'b0;
    chk("done_seen", 32'(done_m), 32'd1);
    if (sbq.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("latency", 32'(j), 32'(e.lat));
      chk("code", 32'(code_m), 32'(e.code));
      chk("match", 32'(match_m), 32'(e.m));
    end
    chk("busy_at_done", 32'(busy_m), 32'd0);
    chk("din_at_done", 32'(din_m), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_code", 32'(code4), 32'd0);
    chk("rst_match", 32'(match4), 32'd0);
    chk("rst_din", 32'(din4), 32'd0);
    reset = 1'b0;
    step();

    sel = 1'b0;
    sweep(0, 8'h64, 8'h64, 1'b1, 1'b0);
    step();
    chk("done_one_cycle", 32'(done4), 32'd0);
    chk("code_hold", 32'(code4), 32'h64);
    chk("match_hold", 32'(match4), 32'd1);

    sweep(1, 8'h64, 8'h00, 1'b0, 1'b0);
    step();
    chk("done_one_cycle_c0", 32'(done4), 32'd0);

    sel = 1'b1;
    step();
    sweep(2, 8'h69, 8'h69, 1'b1, 1'b0);
    step();
    chk("done_one_cycle_s1", 32'(done1), 32'd0);

    sel = 1'b0;
    step();
    sweep(3, 8'h64, 8'h64, 1'b1, 1'b0);
    step();

    // mid-sweep starts ignored, then a start on the done cycle
    sweep(0, 8'h64, 8'h64, 1'b1, 1'b1);
    sweep(1, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    chk("done_one_cycle_chain", 32'(done4), 32'd0);

    mode = 0;
    expected = 8'h64;
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 12; k++) step();
    chk("partial_code", 32'(code4), 32'h60);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_code", 32'(code4), 32'd0);
    chk("midrst_din", 32'(din4), 32'd0);
    chk("midrst_match", 32'(match4), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done4) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    sweep(0, 8'h64, 8'h64, 1'b1, 1'b0);
    step();

    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", 32'(busy4), 32'd0);
    step();
    chk("rst_beats_start2", 32'(busy4), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
